// File: rtl/bnn_pkg.sv
// Shared types and sizes for the BNN byte loader / inference sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bnn_pkg;

    localparam int IMG_BYTES = 113;
    localparam int IMG_BITS  = IMG_BYTES * 8;
    localparam int RESULT_W  = 4;
    localparam int CNT_W     = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_INFER  = 3'd2,
        S_RESULT = 3'd3,
        S_CLEAR  = 3'd4,
        S_ERROR  = 3'd5
    } bnn_seq_state_t;

endpackage

// File: rtl/img_byte_buffer.sv
// Image assembly register: writes each loaded byte at the slot picked by the byte counter, first byte in the MSBs.
// Latency: byte visible on img one cycle after load; last is combinational from the counter.
// Backpressure: none; caller gates load. Ports: load/din write, clr_cnt zeroes the counter, last = counter at final slot.
module img_byte_buffer #(
    parameter int NBYTES = bnn_pkg::IMG_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clr_cnt,
    input  logic [7:0]            din,
    output logic [NBYTES*8-1:0]   img,
    output logic                  last
);
    import bnn_pkg::*;

    logic [NBYTES*8-1:0] img_q, img_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        img_d = img_q;
        cnt_d = cnt_q;
        if (load) begin
            // Constant-index decode: byte k lands at [8*NBYTES-1-8k -: 8].
            for (int i = 0; i < NBYTES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    img_d[(NBYTES-1-i)*8 +: 8] = din;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Clearing wins so the final byte both writes and rewinds the counter.
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= '0;
            cnt_q <= '0;
        end else begin
            img_q <= img_d;
            cnt_q <= cnt_d;
        end
    end

    assign img  = img_q;
    assign last = (cnt_q == CNT_W'(NBYTES-1));

endmodule

// File: rtl/bnn_sequencer.sv
// Loads an image byte stream, sequences one BNN inference, holds the class result until host ack; abort/timeout/overrun.
// Latency: every output registered, one cycle after the causing input.
// Backpressure: none on rx; bytes arriving outside IDLE/LOAD are dropped and flagged on rx_overrun.
module bnn_sequencer #(
    parameter int IMG_BYTES     = bnn_pkg::IMG_BYTES,
    parameter int INFER_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    input  logic                          host_abort,
    input  logic                          result_ack,
    output logic [IMG_BYTES*8-1:0]        img_out,
    output logic                          img_buffer_full,
    output logic                          bnn_enable,
    output logic                          bnn_clear,
    input  logic                          bnn_result_ready,
    input  logic [bnn_pkg::RESULT_W-1:0]  bnn_result,
    output logic [bnn_pkg::RESULT_W-1:0]  result_out,
    output logic                          result_valid,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          rx_overrun
);
    import bnn_pkg::*;

    localparam int TMO_W = (INFER_TIMEOUT > 0) ? $clog2(INFER_TIMEOUT + 1) : 1;
    // Fire on the cycle whose increment would reach INFER_TIMEOUT, so ERROR
    // is entered exactly INFER_TIMEOUT cycles after INFER entry.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((INFER_TIMEOUT > 0) ? INFER_TIMEOUT - 1 : 0);

    bnn_seq_state_t        state_q, state_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  full_q, full_d;
    logic                  en_q, en_d;
    logic                  clr_q, clr_d;
    logic [RESULT_W-1:0]   res_q, res_d;
    logic                  rv_q, rv_d;
    logic                  busy_q, busy_d;
    logic                  terr_q, terr_d;
    logic                  ovr_q, ovr_d;

    logic                  buf_load, buf_clr_cnt, buf_last;

    img_byte_buffer #(.NBYTES(IMG_BYTES)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (buf_load),
        .clr_cnt (buf_clr_cnt),
        .din     (rx_byte),
        .img     (img_out),
        .last    (buf_last)
    );

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        full_d      = full_q;
        en_d        = en_q;
        clr_d       = clr_q;
        res_d       = res_q;
        rv_d        = rv_q;
        terr_d      = terr_q;
        ovr_d       = ovr_q;
        buf_load    = 1'b0;
        buf_clr_cnt = 1'b0;

        if (host_abort) begin
            // Abort outranks everything; the image contents are left alone.
            state_d     = S_IDLE;
            buf_clr_cnt = 1'b1;
            full_d      = 1'b0;
            en_d        = 1'b0;
            clr_d       = 1'b0;
            rv_d        = 1'b0;
            terr_d      = 1'b0;
            ovr_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (rx_valid) begin
                        buf_load = 1'b1;
                        state_d  = S_LOAD;
                        if (buf_last) begin
                            buf_clr_cnt = 1'b1;
                            full_d      = 1'b1;
                            en_d        = 1'b1;
                            tmo_d       = '0;
                            state_d     = S_INFER;
                        end
                    end
                end
                S_INFER: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (bnn_result_ready) begin
                        res_d   = bnn_result;
                        rv_d    = 1'b1;
                        en_d    = 1'b0;
                        state_d = S_RESULT;
                    end else if (INFER_TIMEOUT > 0 && tmo_q == TMO_LAST) begin
                        terr_d  = 1'b1;
                        en_d    = 1'b0;
                        state_d = S_ERROR;
                    end
                end
                S_RESULT: begin
                    if (result_ack && rv_q) begin
                        rv_d    = 1'b0;
                        clr_d   = 1'b1;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // Hold the release request until the BNN side drops ready.
                    if (!bnn_result_ready) begin
                        clr_d   = 1'b0;
                        full_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: ;  // S_ERROR: sticky until abort or reset
            endcase

            if (rx_valid && state_q != S_IDLE && state_q != S_LOAD) begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            full_q  <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            full_q  <= full_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign img_buffer_full = full_q;
    assign bnn_enable      = en_q;
    assign bnn_clear       = clr_q;
    assign result_out      = res_q;
    assign result_valid    = rv_q;
    assign busy            = busy_q;
    assign timeout_err     = terr_q;
    assign rx_overrun      = ovr_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer: instance a uses the default timeout, instance b uses a 16-cycle timeout.
// Latency: inputs change 1 time unit after posedge, outputs sampled at that same point.
// Backpressure: n/a.
module tb_bnn_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_valid = 1'b0;
    logic         host_abort = 1'b0;
    logic         result_ack = 1'b0;
    logic         rdy_a = 1'b0;
    logic         rdy_b = 1'b0;
    logic [3:0]   bnn_result = 4'h0;

    logic [903:0] a_img, b_img;
    logic         a_full, a_en, a_clr, a_rv, a_busy, a_terr, a_ovr;
    logic         b_full, b_en, b_clr, b_rv, b_busy, b_terr, b_ovr;
    logic [3:0]   a_res, b_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bnn_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .host_abort(host_abort), .result_ack(result_ack), .img_out(a_img),
        .img_buffer_full(a_full), .bnn_enable(a_en), .bnn_clear(a_clr),
        .bnn_result_ready(rdy_a), .bnn_result(bnn_result), .result_out(a_res),
        .result_valid(a_rv), .busy(a_busy), .timeout_err(a_terr), .rx_overrun(a_ovr)
    );

    bnn_sequencer #(.INFER_TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .host_abort(host_abort), .result_ack(result_ack), .img_out(b_img),
        .img_buffer_full(b_full), .bnn_enable(b_en), .bnn_clear(b_clr),
        .bnn_result_ready(rdy_b), .bnn_result(bnn_result), .result_out(b_res),
        .result_valid(b_rv), .busy(b_busy), .timeout_err(b_terr), .rx_overrun(b_ovr)
    );

    // Expected image when byte k = base + k.
    function automatic logic [903:0] img_of(input logic [7:0] base);
        logic [903:0] r;
        r = '0;
        for (int k = 0; k < 113; k++) r[903-8*k -: 8] = base + 8'(k);
        return r;
    endfunction

    // First differing byte index, for compact failure messages.
    function automatic int first_diff(input logic [903:0] x, input logic [903:0] y);
        for (int k = 0; k < 113; k++) if (x[903-8*k -: 8] !== y[903-8*k -: 8]) return k;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) send_byte(base + 8'(k));
    endtask

    task automatic abort_all();
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [903:0] exp_img;
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (a_img !== '0) begin errors++; $display("FAIL reset_img: byte %0d nonzero", first_diff(a_img, '0)); end
        checks++; if ({a_full, a_en, a_clr, a_rv, a_busy, a_terr, a_ovr} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b required 0000000", {a_full, a_en, a_clr, a_rv, a_busy, a_terr, a_ovr}); end
        checks++; if (a_res !== 4'h0) begin errors++; $display("FAIL reset_result: got %h required 0", a_res); end
        rst_n = 1'b1;
        tick();
        // Partial frame, then reset asserted between clock edges.
        send_bytes(8'h55, 10);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b required 1", a_busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_img !== '0 || a_busy !== 1'b0) begin errors++; $display("FAIL async_reset: busy %b byte0 %h required 0/00", a_busy, a_img[903:896]); end
        #1 rst_n = 1'b1;
        tick();
        exp_img = '0;
        checks++; if (a_img !== exp_img) begin errors++; $display("FAIL post_reset_img: byte %0d nonzero", first_diff(a_img, exp_img)); end
    endtask

    task automatic test_load_infer();
        logic [903:0] exp_img;
        exp_img = img_of(8'h00);
        send_bytes(8'h00, 112);
        checks++; if (a_full !== 1'b0 || a_en !== 1'b0) begin errors++; $display("FAIL early_full: full %b en %b required 0/0", a_full, a_en); end
        send_byte(8'h70);
        checks++; if ({a_full, a_en, a_busy} !== 3'b111) begin errors++; $display("FAIL load_done: full/en/busy %b required 111", {a_full, a_en, a_busy}); end
        checks++; if (a_img[903:896] !== 8'h00 || a_img[7:0] !== 8'h70) begin errors++; $display("FAIL img_ends: msb %h lsb %h required 00/70", a_img[903:896], a_img[7:0]); end
        checks++; if (a_img !== exp_img) begin errors++; $display("FAIL img_full: byte %0d differs", first_diff(a_img, exp_img)); end
        // Ack with no valid result must be ignored.
        result_ack = 1'b1; tick(); result_ack = 1'b0;
        checks++; if (a_en !== 1'b1 || a_clr !== 1'b0 || a_rv !== 1'b0) begin errors++; $display("FAIL early_ack: en %b clr %b rv %b required 1/0/0", a_en, a_clr, a_rv); end
        repeat (49) tick();
        checks++; if (a_en !== 1'b1 || a_busy !== 1'b1 || a_terr !== 1'b0) begin errors++; $display("FAIL infer_hold: en %b busy %b terr %b required 1/1/0", a_en, a_busy, a_terr); end
        rdy_a = 1'b1; bnn_result = 4'd7;
        tick();
        checks++; if (a_res !== 4'd7 || a_rv !== 1'b1 || a_en !== 1'b0) begin errors++; $display("FAIL result_latch: res %0d rv %b en %b required 7/1/0", a_res, a_rv, a_en); end
        bnn_result = 4'd2;
        tick();
        checks++; if (a_res !== 4'd7 || a_rv !== 1'b1) begin errors++; $display("FAIL result_hold: res %0d rv %b required 7/1", a_res, a_rv); end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
        checks++; if (a_clr !== 1'b1 || a_rv !== 1'b0) begin errors++; $display("FAIL ack_clear: clr %b rv %b required 1/0", a_clr, a_rv); end
        repeat (3) tick();
        checks++; if (a_clr !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL clear_hold: clr %b busy %b required 1/1", a_clr, a_busy); end
        rdy_a = 1'b0;
        tick();
        checks++; if ({a_clr, a_busy, a_full} !== 3'b000) begin errors++; $display("FAIL clear_done: clr/busy/full %b required 000", {a_clr, a_busy, a_full}); end
    endtask

    task automatic test_timeout();
        abort_all();
        send_bytes(8'h80, 113);
        checks++; if (b_en !== 1'b1 || b_full !== 1'b1) begin errors++; $display("FAIL b_infer_entry: en %b full %b required 1/1", b_en, b_full); end
        repeat (15) tick();
        checks++; if (b_terr !== 1'b0 || b_en !== 1'b1) begin errors++; $display("FAIL tmo_early: terr %b en %b required 0/1", b_terr, b_en); end
        tick();
        checks++; if ({b_terr, b_en, b_busy, b_full} !== 4'b1011) begin errors++; $display("FAIL tmo_fire: terr/en/busy/full %b required 1011", {b_terr, b_en, b_busy, b_full}); end
        send_byte(8'h11);
        checks++; if (b_ovr !== 1'b1 || b_img !== img_of(8'h80)) begin errors++; $display("FAIL err_overrun: ovr %b diff byte %0d required 1/-1", b_ovr, first_diff(b_img, img_of(8'h80))); end
        abort_all();
        checks++; if ({b_terr, b_ovr, b_busy, b_full} !== 4'b0000) begin errors++; $display("FAIL tmo_abort: terr/ovr/busy/full %b required 0000", {b_terr, b_ovr, b_busy, b_full}); end
    endtask

    task automatic test_ready_vs_timeout();
        abort_all();
        send_bytes(8'h20, 113);
        repeat (15) tick();
        rdy_b = 1'b1; bnn_result = 4'd9;
        tick();
        checks++; if (b_rv !== 1'b1 || b_res !== 4'd9 || b_terr !== 1'b0 || b_en !== 1'b0) begin errors++; $display("FAIL race: rv %b res %0d terr %b en %b required 1/9/0/0", b_rv, b_res, b_terr, b_en); end
        result_ack = 1'b1; tick(); result_ack = 1'b0;
        rdy_b = 1'b0;
        tick();
        checks++; if (b_busy !== 1'b0 || b_clr !== 1'b0) begin errors++; $display("FAIL race_idle: busy %b clr %b required 0/0", b_busy, b_clr); end
    endtask

    task automatic test_overrun();
        abort_all();
        send_bytes(8'h40, 113);
        rdy_a = 1'b1; bnn_result = 4'd3;
        tick();
        send_byte(8'hEE);
        checks++; if (a_ovr !== 1'b1 || a_rv !== 1'b1 || a_res !== 4'd3) begin errors++; $display("FAIL overrun_flag: ovr %b rv %b res %0d required 1/1/3", a_ovr, a_rv, a_res); end
        checks++; if (a_img !== img_of(8'h40)) begin errors++; $display("FAIL overrun_img: byte %0d changed", first_diff(a_img, img_of(8'h40))); end
        rdy_a = 1'b0;
        abort_all();
        checks++; if ({a_ovr, a_rv, a_busy, a_full} !== 4'b0000) begin errors++; $display("FAIL overrun_abort: ovr/rv/busy/full %b required 0000", {a_ovr, a_rv, a_busy, a_full}); end
        checks++; if (a_img !== img_of(8'h40)) begin errors++; $display("FAIL abort_keeps_img: byte %0d changed", first_diff(a_img, img_of(8'h40))); end
    endtask

    task automatic test_abort_load();
        logic [7:0] b58, b59;
        send_bytes(8'hC0, 59);
        rx_byte = 8'hFF; rx_valid = 1'b1; host_abort = 1'b1;
        tick();
        rx_valid = 1'b0; host_abort = 1'b0;
        b58 = a_img[439:432];
        b59 = a_img[431:424];
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_load_busy: got %b required 0", a_busy); end
        checks++; if (b58 !== 8'hFA || b59 !== 8'h7B) begin errors++; $display("FAIL abort_load_bytes: b58 %h b59 %h required FA/7B", b58, b59); end
        send_bytes(8'h10, 112);
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reload_early_full: got %b required 0", a_full); end
        send_byte(8'h80);
        checks++; if (a_full !== 1'b1 || a_en !== 1'b1) begin errors++; $display("FAIL reload_full: full %b en %b required 1/1", a_full, a_en); end
        checks++; if (a_img !== img_of(8'h10)) begin errors++; $display("FAIL reload_img: byte %0d differs", first_diff(a_img, img_of(8'h10))); end
    endtask

    initial begin
        test_reset();
        test_load_infer();
        test_timeout();
        test_ready_vs_timeout();
        test_overrun();
        test_abort_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
